// File: rtl/fft16_pkg.sv
// rtl/fft16_pkg.sv - shared FFT16 radix-4 controller constants, state enum and twiddle helper
package fft16_pkg;

    localparam int FFT_N    = 16;
    localparam int RADIX    = 4;
    localparam int STAGES   = 2;
    localparam int TW_IDX_W = 4;

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_S0_ISSUE,
        ST_S0_DRAIN,
        ST_S1_ISSUE,
        ST_S1_DRAIN,
        ST_UNLOAD
    } state_t;

    // Stage-0 twiddle exponents for group g: lane q gets W16^(g*q).
    function automatic logic [RADIX*TW_IDX_W-1:0] stage0_tw(input logic [1:0] g);
        logic [TW_IDX_W-1:0] gx;
        gx = {2'b00, g};
        return {gx * 4'd3, gx * 4'd2, gx, 4'd0};
    endfunction

endpackage

// File: rtl/fft16_sample_buf.sv
// rtl/fft16_sample_buf.sv - 16-entry sample buffer, 4 combinational read lanes and 4 write lanes
module fft16_sample_buf #(
    parameter int WIDTH = 72,
    parameter int DEPTH = 16,
    parameter int LANES = 4,
    parameter int AW    = 4
) (
    input  logic                   clk,
    input  logic [LANES-1:0]       wr_en,
    input  logic [LANES*AW-1:0]    wr_addr,
    input  logic [LANES*WIDTH-1:0] wr_data,
    input  logic [LANES*AW-1:0]    rd_addr,
    output logic [LANES*WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        for (int q = 0; q < LANES; q++) begin
            if (wr_en[q]) begin
                mem[wr_addr[q*AW +: AW]] <= wr_data[q*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int q = 0; q < LANES; q++) begin
            rd_data[q*WIDTH +: WIDTH] = mem[rd_addr[q*AW +: AW]];
        end
    end

endmodule

// File: rtl/fft16_r4_ctrl.sv
// rtl/fft16_r4_ctrl.sv - 16-point radix-4 FFT sequencer around an external butterfly; FFT16_R4_CTRL_ERR_EN adds err_o
module fft16_r4_ctrl
    import fft16_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BUF_WIDTH  = DATA_WIDTH + 4
) (
    input  logic                          sys_clk_i,
    input  logic                          sys_rst_i,
    input  logic                          s_valid_i,
    output logic                          s_ready_o,
    input  logic [DATA_WIDTH-1:0]         s_real_i,
    input  logic [DATA_WIDTH-1:0]         s_imag_i,
    output logic                          bf_valid_o,
    output logic [RADIX*BUF_WIDTH-1:0]    bf_xn_real_o,
    output logic [RADIX*BUF_WIDTH-1:0]    bf_xn_imag_o,
    output logic                          bf_tw_en_o,
    output logic [RADIX*TW_IDX_W-1:0]     bf_tw_idx_o,
    input  logic                          bf_valid_i,
    input  logic [RADIX*BUF_WIDTH-1:0]    bf_xk_real_i,
    input  logic [RADIX*BUF_WIDTH-1:0]    bf_xk_imag_i,
    output logic                          m_valid_o,
    input  logic                          m_ready_i,
    output logic [BUF_WIDTH-1:0]          m_real_o,
    output logic [BUF_WIDTH-1:0]          m_imag_o,
    output logic [3:0]                    m_index_o,
    output logic                          m_last_o,
    output logic                          busy_o
`ifdef FFT16_R4_CTRL_ERR_EN
    ,
    output logic                          err_o
`endif
);

    localparam int WW = 2 * BUF_WIDTH;

    state_t                 state;
    logic [3:0]             n_cnt;
    logic [1:0]             grp;
    logic [2:0]             iss_cnt;
    logic [2:0]             rcv_cnt;

    logic [RADIX-1:0]       wr_en;
    logic [RADIX*4-1:0]     wr_addr;
    logic [RADIX*WW-1:0]    wr_data;
    logic [RADIX*4-1:0]     rd_addr;
    logic [RADIX*WW-1:0]    rd_data;

    logic                   stage0;
    logic                   stage1;
    logic                   issuing;
    logic                   load_fire;
    logic                   res_ok;
    logic [3:0]             in_flight;
    logic [3:0]             base;
    logic signed [BUF_WIDTH-1:0] ext_re;
    logic signed [BUF_WIDTH-1:0] ext_im;

    assign stage0    = (state == ST_S0_ISSUE) || (state == ST_S0_DRAIN);
    assign stage1    = (state == ST_S1_ISSUE) || (state == ST_S1_DRAIN);
    assign issuing   = (state == ST_S0_ISSUE) || (state == ST_S1_ISSUE);
    assign load_fire = (state == ST_LOAD) && s_valid_i && s_ready_o;
    assign ext_re    = BUF_WIDTH'($signed(s_real_i));
    assign ext_im    = BUF_WIDTH'($signed(s_imag_i));

    // An issue on the port this cycle already counts as outstanding, so a zero-latency butterfly also works.
    assign in_flight = {1'b0, iss_cnt} + {3'b000, bf_valid_o};
    assign res_ok    = bf_valid_i && (stage0 || stage1) && ({1'b0, rcv_cnt} < in_flight);

    // Both stages read the stride-4 column base, base+4, base+8, base+12; unload reads lane 0 only.
    always_comb begin
        if (issuing) begin
            base = {2'b00, grp};
        end else if (state == ST_UNLOAD) begin
            base = m_index_o + 4'd1;
        end else begin
            base = 4'd0;
        end
        rd_addr = '0;
        for (int q = 0; q < RADIX; q++) begin
            rd_addr[q*4 +: 4] = base + 4'(q * 4);
        end
    end

    always_comb begin
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        if (load_fire) begin
            wr_en[0]        = 1'b1;
            wr_addr[3:0]    = n_cnt;
            wr_data[WW-1:0] = {ext_re, ext_im};
        end else if (res_ok) begin
            for (int q = 0; q < RADIX; q++) begin
                wr_en[q]          = 1'b1;
                wr_addr[q*4 +: 4] = stage0 ? {rcv_cnt[1:0], 2'(q)} : {2'(q), rcv_cnt[1:0]};
                wr_data[q*WW +: WW] = {bf_xk_real_i[q*BUF_WIDTH +: BUF_WIDTH],
                                       bf_xk_imag_i[q*BUF_WIDTH +: BUF_WIDTH]};
            end
        end
    end

    fft16_sample_buf #(
        .WIDTH (WW),
        .DEPTH (FFT_N),
        .LANES (RADIX),
        .AW    (4)
    ) u_buf (
        .clk     (sys_clk_i),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state        <= ST_LOAD;
            n_cnt        <= '0;
            grp          <= '0;
            iss_cnt      <= '0;
            rcv_cnt      <= '0;
            s_ready_o    <= 1'b1;
            bf_valid_o   <= 1'b0;
            bf_tw_en_o   <= 1'b0;
            bf_tw_idx_o  <= '0;
            bf_xn_real_o <= '0;
            bf_xn_imag_o <= '0;
            m_valid_o    <= 1'b0;
            m_last_o     <= 1'b0;
            m_index_o    <= '0;
            m_real_o     <= '0;
            m_imag_o     <= '0;
            busy_o       <= 1'b0;
        end else begin
            if (res_ok) begin
                rcv_cnt <= rcv_cnt + 3'd1;
            end
            if (bf_valid_o) begin
                iss_cnt <= iss_cnt + 3'd1;
            end
            case (state)
                ST_LOAD: begin
                    if (load_fire) begin
                        n_cnt <= n_cnt + 4'd1;
                        if (n_cnt == 4'(FFT_N - 1)) begin
                            state     <= ST_S0_ISSUE;
                            s_ready_o <= 1'b0;
                            busy_o    <= 1'b1;
                            grp       <= '0;
                            iss_cnt   <= '0;
                            rcv_cnt   <= '0;
                        end
                    end
                end
                ST_S0_ISSUE, ST_S1_ISSUE: begin
                    bf_valid_o  <= 1'b1;
                    bf_tw_en_o  <= (state == ST_S0_ISSUE);
                    bf_tw_idx_o <= (state == ST_S0_ISSUE) ? stage0_tw(grp) : '0;
                    for (int q = 0; q < RADIX; q++) begin
                        bf_xn_real_o[q*BUF_WIDTH +: BUF_WIDTH] <= rd_data[q*WW+BUF_WIDTH +: BUF_WIDTH];
                        bf_xn_imag_o[q*BUF_WIDTH +: BUF_WIDTH] <= rd_data[q*WW +: BUF_WIDTH];
                    end
                    grp <= grp + 2'd1;
                    if (grp == 2'd3) begin
                        state <= (state == ST_S0_ISSUE) ? ST_S0_DRAIN : ST_S1_DRAIN;
                    end
                end
                ST_S0_DRAIN, ST_S1_DRAIN: begin
                    bf_valid_o  <= 1'b0;
                    bf_tw_en_o  <= 1'b0;
                    bf_tw_idx_o <= '0;
                    // Leaving only after the fourth write has landed closes the read-after-write hazard.
                    if (rcv_cnt == 3'(RADIX)) begin
                        iss_cnt <= '0;
                        rcv_cnt <= '0;
                        grp     <= '0;
                        if (state == ST_S0_DRAIN) begin
                            state <= ST_S1_ISSUE;
                        end else begin
                            state     <= ST_UNLOAD;
                            m_valid_o <= 1'b1;
                            m_index_o <= '0;
                            m_last_o  <= 1'b0;
                            m_real_o  <= rd_data[WW-1:BUF_WIDTH];
                            m_imag_o  <= rd_data[BUF_WIDTH-1:0];
                        end
                    end
                end
                ST_UNLOAD: begin
                    if (m_valid_o && m_ready_i) begin
                        if (m_last_o) begin
                            state     <= ST_LOAD;
                            m_valid_o <= 1'b0;
                            m_last_o  <= 1'b0;
                            m_index_o <= '0;
                            s_ready_o <= 1'b1;
                            busy_o    <= 1'b0;
                            n_cnt     <= '0;
                        end else begin
                            m_index_o <= m_index_o + 4'd1;
                            m_last_o  <= (m_index_o == 4'd14);
                            m_real_o  <= rd_data[WW-1:BUF_WIDTH];
                            m_imag_o  <= rd_data[BUF_WIDTH-1:0];
                        end
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

`ifdef FFT16_R4_CTRL_ERR_EN
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            err_o <= 1'b0;
        end else if ((bf_valid_i && !res_ok) || (s_valid_i && state != ST_LOAD)) begin
            err_o <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/fft16_r4_ctrl.md
FFT16_R4_CTRL -- requirements
Module: fft16_r4_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the input sample width per real/imag part.
REQ-002 SHALL have parameter BUF_WIDTH, default DATA_WIDTH+4, the internal, butterfly-lane and output width.
REQ-003 SHALL have sys_clk_i  in  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have sys_rst_i  in  1  reset, synchronous and active-high.
REQ-005 SHALL have s_valid_i in 1, s_ready_o out 1, s_real_i in DATA_WIDTH, s_imag_i in DATA_WIDTH: the input sample stream, natural order, one sample per beat.
REQ-006 SHALL have bf_valid_o out 1, bf_xn_real_o out 4*BUF_WIDTH, bf_xn_imag_o out 4*BUF_WIDTH: the butterfly issue port, lane q at bits [BUF_WIDTH*(q+1)-1 : BUF_WIDTH*q].
REQ-007 SHALL have bf_tw_en_o out 1 and bf_tw_idx_o out 16: per-lane twiddle exponent k of W16^k, 4 bits per lane.
REQ-008 SHALL have bf_valid_i in 1, bf_xk_real_i in 4*BUF_WIDTH, bf_xk_imag_i in 4*BUF_WIDTH: the butterfly result port, same lane packing as REQ-006.
REQ-009 SHALL have m_valid_o out 1, m_ready_i in 1, m_real_o out BUF_WIDTH, m_imag_o out BUF_WIDTH, m_index_o out 4, m_last_o out 1: the output stream.
REQ-010 SHALL have busy_o  out  1, high in every state except LOAD.

Function
REQ-011 SHALL sequence one 16-point radix-4 FFT per frame through an external radix-4 butterfly of arbitrary fixed latency.
REQ-012 SHALL implement the FSM LOAD -> S0_ISSUE -> S0_DRAIN -> S1_ISSUE -> S1_DRAIN -> UNLOAD -> LOAD.
REQ-013 LOAD: s_ready_o=1; each s_valid_i beat writes sample n (n = 0..15) sign-extended to BUF_WIDTH; the state exits after n=15.
REQ-014 S0_ISSUE: in each of four consecutive cycles, group g=0..3 SHALL issue with bf_valid_o=1, lanes x[g], x[g+4], x[g+8], x[g+12], bf_tw_en_o=1, and lane q idx = g*q.
REQ-015 A stage-0 result for group g, lane q SHALL be written to buf[4g+q]; results SHALL return in issue order, counted by bf_valid_i.
REQ-016 S0_DRAIN SHALL hold with bf_valid_o=0 until all 4 results have returned; S1_ISSUE SHALL NOT start earlier (read-after-write hazard).
REQ-017 S1_ISSUE: group q=0..3 SHALL issue lanes buf[q], buf[q+4], buf[q+8], buf[q+12] with bf_tw_en_o=0 and idx=0; result lane p SHALL be written to buf[q+4p].
REQ-018 S1_DRAIN SHALL wait for 4 results, then enter UNLOAD.
REQ-019 UNLOAD SHALL present X[k], k=0..15, in natural order; m_index_o=k; m_last_o=1 at k=15; the output SHALL advance only on m_valid_o && m_ready_i and hold stable otherwise.
REQ-020 After the k=15 handshake the block SHALL enter LOAD on the next cycle; s_ready_o SHALL be 0 outside LOAD.
REQ-021 bf_valid_i while no operation is outstanding SHALL be ignored (no buffer write).
REQ-022 Arithmetic: the controller SHALL perform no arithmetic on data, only sign-extension at LOAD; bit growth is the butterfly's responsibility within BUF_WIDTH.

Reset
REQ-023 On sys_rst_i: state=LOAD, counters=0, s_ready_o=1, bf_valid_o=0, bf_tw_en_o=0, bf_tw_idx_o=0, m_valid_o=0, m_last_o=0, m_index_o=0, busy_o=0; buffer contents are don't-care.
REQ-024 Reset mid-frame SHALL abandon the frame; butterfly results arriving after reset SHALL be ignored per REQ-021.

Configuration
REQ-025 With FFT16_R4_CTRL_ERR_EN defined, the block SHALL add port err_o (out, 1), a sticky flag set by a REQ-021 event or by s_valid_i outside LOAD, and cleared only by reset.
REQ-026 Without FFT16_R4_CTRL_ERR_EN, err_o SHALL NOT exist and those events SHALL be silently ignored.

Structure
REQ-027 Package fft16_pkg SHALL hold the FSM state enum, FFT_N=16, RADIX=4, STAGES=2 and TW_IDX_W=4.
REQ-028 The 16-entry, 4-read/4-write-lane buffer SHALL be the sub-module fft16_sample_buf; all sequencing SHALL remain in fft16_r4_ctrl.

Verification (the bench uses a radix-4 butterfly model with twiddle, latency 3)
REQ-029 Impulse: x[0]=1, all other samples 0 -> X[k]=1+0j for all k; m_last_o=1 only at k=15.
REQ-030 DC input: all x[n]=1 -> X[0]=16, X[1..15]=0.
REQ-031 Twiddle check: at stage-0 group 3, bf_tw_idx_o lanes = {0,3,6,9} with bf_tw_en_o=1; every stage-1 issue has bf_tw_en_o=0.
REQ-032 Backpressure: hold m_ready_i=0 for 5 cycles at k=7 -> X[7] and m_index_o=7 stay stable, with no skipped or repeated index.
REQ-033 Reset asserted in S0_DRAIN, then a new impulse frame -> output correct per REQ-029; late results are ignored.
REQ-034 With FFT16_R4_CTRL_ERR_EN: a spurious bf_valid_i in LOAD -> err_o=1 on the next cycle and held until reset.
